// File: rtl/hwag_coil_sequencer.sv
// hwag_coil_sequencer -- N-channel ignition coil driver fed by the angle counter.
//
// Each channel owns a phase offset plus dwell-start (set) and spark (rst)
// angles. Writes land in a shadow copy and are promoted to the active copy only
// while the channel is idle or at the end of a dwell, so a window in flight is
// never reshaped. A max-dwell guard forces the coil off if the spark angle is
// missed (e.g. ACNT jumped over it).
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   sync_ok              angle generator locked; low forces every channel idle
//   acnt, acnt_step      current angle and its 1-cycle advance strobe
//   cfg_we/ch/off/set/rst  config write into a channel shadow
//   cfg_err              1-cycle pulse, write rejected
//   pending[CH]          shadow holds a not-yet-applied write
//   coil_out[CH]         coil drive, 1 = dwelling
//   dwl_fault[CH]        sticky, max-dwell guard fired

// Per-channel lane: S2 (local angle), S3 (FSM), shadow/active config.
module hwag_coil_lane #(
  parameter int ACNT_W = 24,
  parameter int MAXACR = 3839,
  parameter int MAXDWL = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sync_ok,
  input  logic              s1_step,
  input  logic [ACNT_W-1:0] s1_acnt,
  input  logic              wr,
  input  logic [ACNT_W-1:0] wr_off,
  input  logic [ACNT_W-1:0] wr_set,
  input  logic [ACNT_W-1:0] wr_rst,
  output logic              pending,
  output logic              coil_out,
  output logic              dwl_fault
);
  localparam int DW = $clog2(MAXDWL + 1);
  localparam logic [ACNT_W:0] LAST = (ACNT_W+1)'(MAXACR);
  localparam logic [ACNT_W:0] REV  = (ACNT_W+1)'(MAXACR + 1);

  typedef enum logic [1:0] {IDLE, WAIT_SET, DWELL} state_t;
  state_t state, state_n;

  logic [DW-1:0]     cnt, cnt_n;
  logic [ACNT_W-1:0] act_off, act_set, act_rst;
  logic [ACNT_W-1:0] sh_off, sh_set, sh_rst;
  logic [ACNT_W:0]   sum, local_q;
  logic              step_q, fault_set, apply;

  // Offset add with one conditional subtract; both operands <= MAXACR so a
  // single wrap is always enough.
  always_comb begin
    sum = {1'b0, s1_acnt} + {1'b0, act_off};
    if (sum > LAST) sum = sum - REV;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q  <= 1'b0;
      local_q <= '0;
    end else begin
      step_q  <= s1_step;
      local_q <= sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Spark wins over the guard when both land on the same step, so a window of
  // exactly MAXDWL steps ends cleanly.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    fault_set = 1'b0;
    if (!sync_ok) begin
      state_n = IDLE;
    end else if (step_q) begin
      unique case (state)
        IDLE:     state_n = WAIT_SET;
        WAIT_SET: if (local_q == {1'b0, act_set}) begin
                    state_n = DWELL;
                    cnt_n   = '0;
                  end
        DWELL: begin
          cnt_n = cnt + DW'(1);
          if (local_q == {1'b0, act_rst}) begin
            state_n = WAIT_SET;
          end else if (cnt_n == DW'(MAXDWL)) begin
            state_n   = WAIT_SET;
            fault_set = 1'b1;
          end
        end
        default:  state_n = IDLE;
      endcase
    end
  end

  assign apply = pending && (state == IDLE || (state == DWELL && state_n == WAIT_SET));

  // Apply uses the pre-edge shadow; a same-cycle write then refills it and
  // keeps pending set.
  always_ff @(posedge clk) begin
    if (rst) begin
      {act_off, act_set, act_rst} <= '0;
      {sh_off, sh_set, sh_rst}    <= '0;
      pending                     <= 1'b0;
      dwl_fault                   <= 1'b0;
    end else begin
      if (fault_set) dwl_fault <= 1'b1;
      if (apply) begin
        {act_off, act_set, act_rst} <= {sh_off, sh_set, sh_rst};
        pending                     <= 1'b0;
      end
      if (wr) begin
        {sh_off, sh_set, sh_rst} <= {wr_off, wr_set, wr_rst};
        pending                  <= 1'b1;
      end
    end
  end

  always_comb coil_out = (state == DWELL);
endmodule

module hwag_coil_sequencer #(
  parameter  int CH     = 4,
  parameter  int ACNT_W = 24,
  parameter  int MAXACR = 3839,
  parameter  int MAXDWL = 480,
  localparam int CHW    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sync_ok,
  input  logic [ACNT_W-1:0] acnt,
  input  logic              acnt_step,
  input  logic              cfg_we,
  input  logic [CHW-1:0]    cfg_ch,
  input  logic [ACNT_W-1:0] cfg_off,
  input  logic [ACNT_W-1:0] cfg_set,
  input  logic [ACNT_W-1:0] cfg_rst,
  output logic              cfg_err,
  output logic [CH-1:0]     pending,
  output logic [CH-1:0]     coil_out,
  output logic [CH-1:0]     dwl_fault
);
  localparam logic [ACNT_W-1:0] LAST = ACNT_W'(MAXACR);

  logic              cfg_ok, s1_step;
  logic [ACNT_W-1:0] s1_acnt;

  always_comb
    cfg_ok = (32'(cfg_ch) < 32'(CH)) && (cfg_off <= LAST) && (cfg_set <= LAST) &&
             (cfg_rst <= LAST) && (cfg_set != cfg_rst);

  // S1 and the reject pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_step <= 1'b0;
      s1_acnt <= '0;
      cfg_err <= 1'b0;
    end else begin
      s1_step <= acnt_step;
      s1_acnt <= acnt;
      cfg_err <= cfg_we && !cfg_ok;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_lane
    logic lane_wr;
    assign lane_wr = cfg_we && cfg_ok && (cfg_ch == CHW'(i));
    hwag_coil_lane #(.ACNT_W(ACNT_W), .MAXACR(MAXACR), .MAXDWL(MAXDWL)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .sync_ok   (sync_ok),
      .s1_step   (s1_step),
      .s1_acnt   (s1_acnt),
      .wr        (lane_wr),
      .wr_off    (cfg_off),
      .wr_set    (cfg_set),
      .wr_rst    (cfg_rst),
      .pending   (pending[i]),
      .coil_out  (coil_out[i]),
      .dwl_fault (dwl_fault[i])
    );
  end
endmodule

// File: tb/tb_hwag_coil_sequencer.sv
// Scoreboard bench for hwag_coil_sequencer: a rule-level reference model runs on
// every clock edge and queues the expected outputs; a negedge monitor compares.
module tb_hwag_coil_sequencer;
  localparam int CH = 4, AW = 24, MAXACR = 3839, MAXDWL = 480, REV = MAXACR + 1;

  logic          clk = 1'b0, rst, sync_ok, acnt_step, cfg_we;
  logic [AW-1:0] acnt, cfg_off, cfg_set, cfg_rst;
  logic [1:0]    cfg_ch;
  logic          cfg_err;
  logic [CH-1:0] pending, coil_out, dwl_fault;

  hwag_coil_sequencer #(.CH(CH), .ACNT_W(AW), .MAXACR(MAXACR), .MAXDWL(MAXDWL)) dut (
    .clk(clk), .rst(rst), .sync_ok(sync_ok), .acnt(acnt), .acnt_step(acnt_step),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_off(cfg_off), .cfg_set(cfg_set),
    .cfg_rst(cfg_rst), .cfg_err(cfg_err), .pending(pending), .coil_out(coil_out),
    .dwl_fault(dwl_fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0] coil, pend, fault;
    logic          err;
  } exp_t;
  typedef struct {int off; int set_a; int rst_a;} cfg_t;

  exp_t exp_q[$];
  int   n_checks = 0, n_fail = 0, cyc = 0;

  // Reference model: 0 idle, 1 waiting for dwell start, 2 dwelling.
  int   m_st[CH], m_cnt[CH];
  bit   m_pend[CH], m_fault[CH], m_err;
  cfg_t m_act[CH], m_sh[CH];
  // Step history: a step seen at edge e is acted on two edges later.
  int   d1a, d2a;
  bit   d1s, d2s;

  task automatic model_edge();
    bit ok;
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        m_st[c] = 0; m_cnt[c] = 0; m_pend[c] = 0; m_fault[c] = 0;
        m_act[c] = '{0, 0, 0}; m_sh[c] = '{0, 0, 0};
      end
      m_err = 0; d1a = 0; d2a = 0; d1s = 0; d2s = 0;
    end else begin
      ok = int'(cfg_ch) < CH && int'(cfg_off) <= MAXACR && int'(cfg_set) <= MAXACR &&
           int'(cfg_rst) <= MAXACR && cfg_set != cfg_rst;
      m_err = cfg_we && !ok;
      for (int c = 0; c < CH; c++) begin
        int st, nst, loc;
        st = m_st[c]; nst = st;
        if (!sync_ok) nst = 0;
        else if (d2s) begin
          loc = (d2a + m_act[c].off) % REV;
          if (st == 0) nst = 1;
          else if (st == 1) begin
            if (loc == m_act[c].set_a) begin nst = 2; m_cnt[c] = 0; end
          end else begin
            m_cnt[c]++;
            if (loc == m_act[c].rst_a) nst = 1;
            else if (m_cnt[c] == MAXDWL) begin nst = 1; m_fault[c] = 1; end
          end
        end
        if (m_pend[c] && (st == 0 || (st == 2 && nst == 1))) begin
          m_act[c] = m_sh[c]; m_pend[c] = 0;
        end
        if (cfg_we && ok && int'(cfg_ch) == c) begin
          m_sh[c] = '{int'(cfg_off), int'(cfg_set), int'(cfg_rst)}; m_pend[c] = 1;
        end
        m_st[c] = nst;
      end
      d2s = d1s; d2a = d1a; d1s = acnt_step; d1a = int'(acnt);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    model_edge();
    for (int c = 0; c < CH; c++) begin
      e.coil[c] = (m_st[c] == 2); e.pend[c] = m_pend[c]; e.fault[c] = m_fault[c];
    end
    e.err = m_err;
    exp_q.push_back(e);
    #1;
    cfg_we = 1'b0; acnt_step = 1'b0;
  endtask

  task automatic set_cfg(input int ch, input int off, input int s, input int r);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_off = AW'(off); cfg_set = AW'(s); cfg_rst = AW'(r);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks += 4;
      if (coil_out !== e.coil) begin
        n_fail++; $display("FAIL coil_out cyc=%0d got=%b exp=%b", cyc, coil_out, e.coil);
      end
      if (pending !== e.pend) begin
        n_fail++; $display("FAIL pending cyc=%0d got=%b exp=%b", cyc, pending, e.pend);
      end
      if (dwl_fault !== e.fault) begin
        n_fail++; $display("FAIL dwl_fault cyc=%0d got=%b exp=%b", cyc, dwl_fault, e.fault);
      end
      if (cfg_err !== e.err) begin
        n_fail++; $display("FAIL cfg_err cyc=%0d got=%b exp=%b", cyc, cfg_err, e.err);
      end
    end
  end

  // One full revolution, one step every two cycles. Rev 1 rewrites ch0
  // mid-dwell; rev 2 drops sync_ok while ch0 is dwelling.
  task automatic run_rev(input int rev_id);
    for (int k = 0; k <= MAXACR; k++) begin
      acnt = AW'(k); acnt_step = 1'b1;
      if (rev_id == 1 && k == 3500) set_cfg(0, 0, 3000, 3839);
      tick(); tick();
      if (rev_id == 2 && k == 3400) begin
        sync_ok = 1'b0; tick(); tick(); sync_ok = 1'b1; tick();
      end
    end
  endtask

  initial begin
    int a;
    rst = 1'b1; sync_ok = 1'b0; acnt = '0; acnt_step = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_off = '0; cfg_set = '0; cfg_rst = '0;
    repeat (3) tick();
    rst = 1'b0; tick();

    // Channel setup while idle, then rejected writes (set==rst, out of range).
    set_cfg(0, 0, 3359, 3839);    tick();
    set_cfg(1, 1920, 3359, 3839); tick();
    set_cfg(2, 0, 3800, 40);      tick();
    set_cfg(3, 0, 100, 900);      tick();
    set_cfg(1, 0, 50, 50);        tick();
    set_cfg(2, 0, 3840, 100);     tick();
    set_cfg(0, 3840, 1, 2);       tick();
    set_cfg(3, 0, 100, 4000);     tick();
    repeat (3) tick();

    sync_ok = 1'b1;
    for (int r = 0; r < 3; r++) run_rev(r);

    // Random phase: occasional angle jumps, config writes (some illegal),
    // step gaps of 2-3 cycles and short sync drops.
    a = 0;
    for (int n = 0; n < 3 * REV; n++) begin
      if ($urandom_range(499) == 0) a = $urandom_range(MAXACR);
      else a = (a == MAXACR) ? 0 : a + 1;
      acnt = AW'(a); acnt_step = 1'b1;
      if ($urandom_range(39) == 0) begin
        int s, r, o;
        o = $urandom_range(MAXACR);
        s = $urandom_range(MAXACR);
        r = (s + $urandom_range(600, 1)) % REV;
        case ($urandom_range(7))
          0: r = s;
          1: s = MAXACR + $urandom_range(200, 1);
          2: o = MAXACR + 1;
          default: ;
        endcase
        set_cfg($urandom_range(CH - 1), o, s, r);
      end
      tick();
      repeat ($urandom_range(2, 1)) tick();
      if ($urandom_range(1999) == 0) begin
        sync_ok = 1'b0; repeat ($urandom_range(5, 1)) tick(); sync_ok = 1'b1;
      end
    end

    // Reset must clear sticky faults and everything else.
    rst = 1'b1; tick(); tick();
    rst = 1'b0; tick(); tick();
    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
